mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Round-robin arbiter and sequencer that lets NUM_CORES per-core cache controllers share the single main-memory port of the multicore RISC-V system.
- Grants one core at a time and latches that core's request.
- Drives the memory handshake to completion or timeout, then returns read data and a one-cycle ack to the winning core.
- Sits between the per-core cache controllers and the memory model.

Parameters:
- NUM_CORES, 2, number of requesting cores (2..8).
- TIMEOUT, 16, maximum cycles spent waiting for mem_ready before the transaction is aborted with error (≥2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  NUM_CORES  per-core request; held high until that core's ack.
- we  in  NUM_CORES  per-core write enable (1 = write, 0 = read).
- addr  in  NUM_CORES*32  per-core address; core i occupies bits [32i+31:32i].
- wdata  in  NUM_CORES*32  per-core write data, same packing as addr.
- grant  out  NUM_CORES  one-hot; identifies the core owning the bus.
- ack  out  NUM_CORES  one-hot, one-cycle completion pulse to the winner.
- err  out  1  valid with ack; 1 = timeout abort.
- rdata  out  32  read data, valid with ack; broadcast to all cores.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_ready  in  1  memory completion; sampled only while in BUSY.
- mem_rdata  in  32  memory read data, valid with mem_ready.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, rr_ptr=0, timeout counter=0.
  - grant, ack, err, rdata, mem_req, mem_we, mem_addr, mem_wdata all 0.
  - Reset during BUSY aborts the transaction silently; no ack is issued.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If req!=0, pick the first requesting core at index ≥ rr_ptr, wrapping modulo NUM_CORES.
  - On that edge: register grant one-hot, latch the winner's we/addr/wdata into mem_we/mem_addr/mem_wdata, set mem_req=1, clear the counter, go to BUSY.
  - If req==0, stay in IDLE with all outputs 0.
- BUSY:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable. The winner's req, we, addr and wdata are ignored after the latch.
  - mem_ready==1: register rdata=mem_rdata (rdata=0 for writes), err=0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT-1: err=1, rdata=0, go to RESP. Else increment the counter.
  - mem_ready and timeout expiry in the same cycle: mem_ready wins, err=0.
- RESP:
  - mem_req=0, ack=grant for exactly one cycle, err and rdata valid.
  - rr_ptr=(winner+1) mod NUM_CORES.
  - Next state IDLE; grant clears on leaving RESP.
- Latency:
  - req first high in IDLE at edge n → mem_req high after edge n.
  - mem_ready sampled high at edge k → ack high after edge k.
  - Minimum request-to-ack is 2 cycles. Back-to-back grants are separated by one IDLE cycle.
- Requester rules:
  - A core drops req no later than the cycle after its ack. req still high in IDLE is treated as a new request.
  - A core dropping req while BUSY does not cancel the transaction; ack is still pulsed.
- Fairness: a core that requests continuously is granted within NUM_CORES transactions.

Decomposition:
- Package arb_pkg:
  - arb_state_t enum {IDLE, BUSY, RESP}.
  - WORD_W=32.
  - Helper function for one-hot to index conversion.
- Sub-module rr_picker (combinational):
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot winner and its index.
  - Instantiated once.

Test Plan:
1. Single read: core0 req=1, we=0, addr=0x100; mem_ready=1 two cycles after mem_req with mem_rdata=0xDEADBEEF → mem_addr=0x100, ack=2'b01, rdata=0xDEADBEEF, err=0; rr_ptr becomes 1.
2. Contention: both cores req every cycle, each holding until ack, mem_ready immediate → grant sequence 01,10,01,10; ack never goes to both cores at once.
3. Write: core1 we=1, addr=0x20, wdata=0x12345678 → mem_we=1, mem_wdata=0x12345678 held stable until mem_ready; ack=2'b10; rdata=0.
4. Timeout: core0 read with mem_ready never asserted, TIMEOUT=16 → ack=2'b01 and err=1 after 16 BUSY cycles, rdata=0; mem_ready arriving on the final BUSY cycle gives err=0 instead.
5. Mid-operation changes:
   - core0 changes addr to 0x200 while BUSY → mem_addr stays 0x100.
   - reset pulsed low while BUSY → all outputs 0 immediately, no ack; next request is arbitrated from rr_ptr=0.
6. Idle: req=0 for 20 cycles → mem_req=0, grant=0 and ack=0 throughout.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and helpers for the memory bus arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package arb_pkg;

  localparam int WORD_W    = 32;
  localparam int MAX_CORES = 8;
  localparam int IDX_W     = 3;   // enough to index MAX_CORES cores

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // One-hot (or all-zero) vector to binary index; all-zero maps to 0.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_CORES-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CORES; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of core-side and memory-side signals of the shared memory port.
// Latency: n/a (wires only).
// Backpressure: cores hold req until ack; memory completes with mem_ready.
// Modports: master = arbiter view, slave = cores + memory view.
interface mem_bus_arbiter_if
  import arb_pkg::*;
#(
  parameter int NUM_CORES = 2
);
  logic [NUM_CORES-1:0]        req;
  logic [NUM_CORES-1:0]        we;
  logic [NUM_CORES*WORD_W-1:0] addr;
  logic [NUM_CORES*WORD_W-1:0] wdata;
  logic [NUM_CORES-1:0]        grant;
  logic [NUM_CORES-1:0]        ack;
  logic                        err;
  logic [WORD_W-1:0]           rdata;
  logic                        mem_req;
  logic                        mem_we;
  logic [WORD_W-1:0]           mem_addr;
  logic [WORD_W-1:0]           mem_wdata;
  logic                        mem_ready;
  logic [WORD_W-1:0]           mem_rdata;

  modport master (
    input  req, we, addr, wdata, mem_ready, mem_rdata,
    output grant, ack, err, rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req, we, addr, wdata, mem_ready, mem_rdata,
    input  grant, ack, err, rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Round-robin pick: first requester at index >= rr_ptr, wrapping to the lowest.
// Latency: combinational.
// Backpressure: none; result is only consumed when the arbiter is idle.
// Ports: req (request vector), rr_ptr (search start) -> win_oh, win_idx.
module rr_picker
  import arb_pkg::*;
#(
  parameter int NUM_CORES = 2
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [NUM_CORES-1:0] win_oh,
  output logic [IDX_W-1:0]     win_idx
);

  logic [NUM_CORES-1:0] hi_oh;
  logic [NUM_CORES-1:0] lo_oh;
  logic                 hi_found;
  logic                 lo_found;

  // hi_*: lowest requester at or above rr_ptr; lo_*: lowest requester overall,
  // used when nothing at or above rr_ptr is asking (the wrap-around case).
  always_comb begin
    hi_oh    = '0;
    lo_oh    = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (req[i] && !lo_found) begin
        lo_oh[i] = 1'b1;
        lo_found = 1'b1;
      end
      if (req[i] && (IDX_W'(i) >= rr_ptr) && !hi_found) begin
        hi_oh[i] = 1'b1;
        hi_found = 1'b1;
      end
    end
    win_oh  = hi_found ? hi_oh : lo_oh;
    win_idx = onehot_to_idx(MAX_CORES'(win_oh));
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one main-memory port among NUM_CORES cache controllers.
// Latency: req in IDLE -> mem_req next cycle; mem_ready -> one-cycle ack next cycle.
// Backpressure: winner held until mem_ready or TIMEOUT cycles in BUSY (then err=1).
// Ports: clk, reset (async, active-low), bus (mem_bus_arbiter_if.master).
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT);

  arb_state_t           state_q,     state_d;
  logic [IDX_W-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [NUM_CORES-1:0] grant_q,     grant_d;
  logic [NUM_CORES-1:0] ack_q,       ack_d;
  logic                 err_q,       err_d;
  logic [WORD_W-1:0]    rdata_q,     rdata_d;
  logic                 mem_req_q,   mem_req_d;
  logic                 mem_we_q,    mem_we_d;
  logic [WORD_W-1:0]    mem_addr_q,  mem_addr_d;
  logic [WORD_W-1:0]    mem_wdata_q, mem_wdata_d;

  logic [NUM_CORES-1:0] win_oh;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     owner_idx;

  rr_picker #(.NUM_CORES(NUM_CORES)) u_picker (
    .req     (bus.req),
    .rr_ptr  (rr_ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

  assign owner_idx = onehot_to_idx(MAX_CORES'(grant_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    ack_d       = '0;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        grant_d     = '0;
        err_d       = 1'b0;
        rdata_d     = '0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (|bus.req) begin
          state_d   = BUSY;
          grant_d   = win_oh;
          mem_req_d = 1'b1;
          cnt_d     = '0;
          // Latch the winner's request; its inputs are ignored from here on.
          for (int i = 0; i < NUM_CORES; i++) begin
            if (IDX_W'(i) == win_idx) begin
              mem_we_d    = bus.we[i];
              mem_addr_d  = bus.addr[i*WORD_W +: WORD_W];
              mem_wdata_d = bus.wdata[i*WORD_W +: WORD_W];
            end
          end
        end
      end

      BUSY: begin
        // mem_ready takes priority over a timeout expiring on the same cycle.
        if (bus.mem_ready) begin
          state_d   = RESP;
          ack_d     = grant_q;
          err_d     = 1'b0;
          rdata_d   = mem_we_q ? '0 : bus.mem_rdata;
          mem_req_d = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = RESP;
          ack_d     = grant_q;
          err_d     = 1'b1;
          rdata_d   = '0;
          mem_req_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        state_d     = IDLE;
        grant_d     = '0;
        err_d       = 1'b0;
        rdata_d     = '0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        rr_ptr_d    = (owner_idx == IDX_W'(NUM_CORES - 1)) ? '0 : owner_idx + IDX_W'(1);
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.grant     = grant_q;
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
